// File: rtl/usb_rx_packet_fifo_if.sv
// Bus bundle between usb_rx / bus-side reader and the packet receive FIFO.
// The master drives the write/commit/read requests; the FIFO (slave) returns
// read data and occupancy status.
interface usb_rx_packet_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  w_enable;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  commit;
   logic                  discard;
   logic                  r_enable;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  commit_err;

   modport master (
      output w_enable, w_data, commit, discard, r_enable,
      input  r_data, empty, full, almost_full, count, overflow, commit_err
   );

   modport slave (
      input  w_enable, w_data, commit, discard, r_enable,
      output r_data, empty, full, almost_full, count, overflow, commit_err
   );
endinterface

// File: rtl/usb_rx_packet_fifo.sv
// Packet-aware receive FIFO. Bytes of the packet in flight sit between
// cmt_ptr and wr_ptr and stay invisible to the reader until the packet is
// committed; a discard (or a commit after an overflow) rewinds wr_ptr to the
// commit boundary so a bad packet never reaches the reader.
// Pointers carry one extra MSB so full and empty stay distinguishable.
module usb_rx_packet_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int AF_THRESH  = DEPTH - 4
) (
   input  logic              clk,
   input  logic              rst,
   usb_rx_packet_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] cmt_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] used;

   logic [DATA_WIDTH-1:0] r_data_q;
   logic overflow_q;
   logic commit_err_q;

   logic empty_c;
   logic full_c;
   logic drop_pkt;
   logic take_pkt;
   logic wr_accept;
   logic rd_fire;

   // Occupancy flags, all derived from the registered pointers.
   always_comb begin
      used    = wr_ptr - rd_ptr;
      empty_c = (rd_ptr == cmt_ptr);
      full_c  = (used == DEPTH_P);
   end

   // Per-cycle decisions. A commit arriving after an overflow is downgraded
   // to a discard, so the truncated packet is dropped as a whole.
   always_comb begin
      drop_pkt  = bus.discard || (bus.commit && overflow_q);
      take_pkt  = bus.commit && !bus.discard && !overflow_q;
      wr_accept = bus.w_enable && !full_c && !drop_pkt;
      rd_fire   = bus.r_enable && !empty_c;
   end

   // Storage array; only accepted writes land, contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr[AW-1:0]] <= bus.w_data;
      end
   end

   // Speculative write pointer: advances on accepted writes, rewinds on drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (drop_pkt) begin
         wr_ptr <= cmt_ptr;
      end else if (wr_accept) begin
         wr_ptr <= wr_ptr + ONE_P;
      end
   end

   // Commit boundary: a write in the commit cycle belongs to the packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmt_ptr <= '0;
      end else if (take_pkt) begin
         cmt_ptr <= wr_accept ? (wr_ptr + ONE_P) : wr_ptr;
      end
   end

   // Read side: pops against the pre-edge commit boundary, data registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         r_data_q <= '0;
      end else if (rd_fire) begin
         rd_ptr   <= rd_ptr + ONE_P;
         r_data_q <= mem[rd_ptr[AW-1:0]];
      end
   end

   // Overflow is sticky for the packet in flight; any packet end clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (bus.commit || bus.discard) begin
         overflow_q <= 1'b0;
      end else if (bus.w_enable && full_c) begin
         overflow_q <= 1'b1;
      end
   end

   // Single-cycle flag for a commit that had to be turned into a discard.
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_err_q <= 1'b0;
      end else begin
         commit_err_q <= bus.commit && !bus.discard && overflow_q;
      end
   end

   assign bus.r_data      = r_data_q;
   assign bus.empty       = empty_c;
   assign bus.full        = full_c;
   assign bus.almost_full = (used >= AF_P);
   assign bus.count       = cmt_ptr - rd_ptr;
   assign bus.overflow    = overflow_q;
   assign bus.commit_err  = commit_err_q;

endmodule

// File: doc/usb_rx_packet_fifo.md
Name: usb_rx_packet_fifo

Overview:
Parametrised packet-aware receive FIFO between usb_rx and the bus-side reader. It supersedes the plain byte fifo.
- Bytes written during a packet are held speculatively.
- On packet_done they are committed and become readable.
- On r_error they are rolled back, so the reader never sees bytes from a bad packet.
- Adds occupancy count, almost_full and overflow reporting.

Parameters:
DATA_WIDTH, 8, width of each stored word.
DEPTH, 64, number of entries; must be a power of two, minimum 4.
AF_THRESH, DEPTH-4, committed-plus-speculative occupancy at or above which almost_full asserts.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
w_enable  input  1  write w_data into the speculative region this cycle.
w_data  input  DATA_WIDTH  write data (usb_rx rx_packet_data).
commit  input  1  end of good packet; make all speculative words readable.
discard  input  1  bad packet; drop all speculative words.
r_enable  input  1  pop one committed word.
r_data  output  DATA_WIDTH  registered read data.
empty  output  1  no committed words.
full  output  1  no free entry (committed plus speculative = DEPTH).
almost_full  output  1  committed plus speculative >= AF_THRESH.
count  output  log2(DEPTH)+1  committed words available to read.
overflow  output  1  sticky: a write was dropped in the current packet.
commit_err  output  1  one-cycle pulse: commit was converted to discard because overflow was set.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array plus three pointers, each log2(DEPTH)+1 bits and wrapping modulo 2*DEPTH:
  - wr_ptr: speculative write pointer.
  - cmt_ptr: commit boundary.
  - rd_ptr: read pointer.
- Reset (rst high at a rising edge): all pointers = 0, r_data = 0, overflow = 0, commit_err = 0. Outputs therefore read empty = 1, full = 0, almost_full = 0, count = 0. Reset overrides every other input, including mid-packet, and discards all contents.
- Flags are combinational from the registered pointers:
  - empty = (rd_ptr == cmt_ptr).
  - used = wr_ptr - rd_ptr; full = (used == DEPTH); almost_full = (used >= AF_THRESH).
  - count = cmt_ptr - rd_ptr.
- Write:
  - w_enable && !full: mem[wr_ptr] <= w_data; wr_ptr += 1.
  - w_enable && full: word dropped, overflow <= 1.
  - A read in the same cycle does not free space for that write; full is evaluated before the edge.
- Commit (commit && !discard):
  - overflow = 0: cmt_ptr <= wr_ptr, plus 1 if a write is accepted in the same cycle (the coincident byte is included in the packet).
  - overflow = 1: treated as discard; commit_err pulses high for exactly one cycle.
  - overflow clears in both cases.
- Discard (discard high; wins over a simultaneous commit): wr_ptr <= cmt_ptr; any same-cycle write is ignored; overflow <= 0; commit_err stays 0.
- Read:
  - r_enable && !empty: r_data <= mem[rd_ptr]; rd_ptr += 1. r_data is valid after the rising edge that samples r_enable (1-cycle latency).
  - r_enable && empty: ignored; r_data holds its last value and no pointer moves.
- Simultaneous read/write/commit is legal. The read uses pre-edge cmt_ptr, so a word committed this cycle is readable from the next cycle.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. The MSB distinguishes full from empty; no other wrap handling is needed.
- Commit or discard with no speculative words: no pointer change, no error.
- r_data is never modified by writes, commit or discard.

Test Plan:
- Nominal (DEPTH=64): reset, write 0x07, 0x01, 0x02, 0x03, pulse commit, then 4 reads -> r_data = 07, 01, 02, 03 in order; count 4→0; empty = 1 after the last read.
- Discard: commit packet {0xAA}, write {0x11, 0x22}, pulse discard, write {0x33} and commit -> reads return AA then 33; count never exceeds 2.
- Overflow (DEPTH=8, AF_THRESH=4):
  - Write 9 bytes -> almost_full high from the 4th write; full after the 8th; 9th dropped with overflow = 1.
  - Commit -> commit_err pulses once; empty = 1; count = 0; overflow = 0.
- Commit with coincident write: write 0x5A with commit high in the same cycle after 2 prior writes -> count = 3 next cycle; the third read returns 0x5A. Read on empty -> r_data unchanged.
- Wrap/pipelined: DEPTH=8, repeatedly write+commit 3 bytes and read 3, 20 iterations -> data in order, no spurious full/empty, pointers wrap cleanly.
- Reset mid-operation: 3 committed plus 2 speculative words, assert rst for 1 cycle -> empty = 1, count = 0, r_data = 0, overflow = 0; a subsequent read does nothing.
